// File: rtl/bus_pkg.sv
// Shared definitions for data-port masters: bus widths and the copy-engine
// FSM state encoding, reused by the future CPU/DMA arbiter.
package bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        st_idle   = 3'd0,
        st_req    = 3'd1,
        st_rd     = 3'd2,
        st_rdwait = 3'd3,
        st_wr     = 3'd4,
        st_done   = 3'd5
    } bus_state_e;

    // A transfer is a 16-bit double whenever at least two bytes remain.
    function automatic logic is_dbl(input logic [ADDR_W:0] rem);
        return (rem >= (ADDR_W + 1)'(2));
    endfunction

endpackage

// File: rtl/bus_copy_engine_if.sv
// Memory data port shared by bus masters: request/grant plus the
// address/data/strobe signals of the 12-bit-address, 16-bit-data port.
interface bus_copy_engine_if;
    import bus_pkg::*;

    // Handshake: a master holds bus_req high while it wants or owns the port;
    // bus_gnt is only honoured between transfers, and once a master starts a
    // read/write pair it finishes it, so grant may only drop while the master
    // is waiting between transfers. Idle masters drive all bus outputs to 0
    // so the arbiter can OR-combine them.
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] address_bus;
    logic [DATA_W-1:0] data_bus;
    logic [DATA_W-1:0] incoming_data_bus;
    logic              write_mode;
    logic              doubleRead;
    logic              doubleWrite;

    modport master (
        output bus_req,
        input  bus_gnt,
        output address_bus,
        output data_bus,
        input  incoming_data_bus,
        output write_mode,
        output doubleRead,
        output doubleWrite
    );

    modport slave (
        input  bus_req,
        output bus_gnt,
        input  address_bus,
        input  data_bus,
        output incoming_data_bus,
        input  write_mode,
        input  doubleRead,
        input  doubleWrite
    );

endinterface

// File: rtl/bus_copy_engine.sv
// Block-copy bus master: copies length bytes from src_addr to dst_addr
// through the shared data port, using 16-bit transfers while >=2 bytes remain.
module bus_copy_engine
    import bus_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    bus_copy_engine_if.master   bus,
    output bus_state_e          state
);

    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] rd_buf;
    logic              dbl;
    logic              write_mode_q;
    logic [ADDR_W:0]   step;

    assign step = {{(ADDR_W-1){1'b0}}, dbl, ~dbl};

    // rd_buf persists after WR; masking keeps data_bus at 0 outside WR.
    assign bus.data_bus   = rd_buf & {DATA_W{write_mode_q}};
    assign bus.write_mode = write_mode_q;

    // Bus outputs are registered one state ahead so they are valid for the
    // whole RD / WR cycle and cleared by default everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= st_idle;
            busy            <= 1'b0;
            done            <= 1'b0;
            src_ptr         <= '0;
            dst_ptr         <= '0;
            remaining       <= '0;
            rd_buf          <= '0;
            dbl             <= 1'b0;
            write_mode_q    <= 1'b0;
            bus.bus_req     <= 1'b0;
            bus.address_bus <= '0;
            bus.doubleRead  <= 1'b0;
            bus.doubleWrite <= 1'b0;
        end else begin
            done            <= 1'b0;
            write_mode_q    <= 1'b0;
            bus.address_bus <= '0;
            bus.doubleRead  <= 1'b0;
            bus.doubleWrite <= 1'b0;
            case (state)
                st_idle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            src_ptr     <= src_addr;
                            dst_ptr     <= dst_addr;
                            remaining   <= length;
                            bus.bus_req <= 1'b1;
                            state       <= st_req;
                        end else begin
                            done  <= 1'b1;
                            state <= st_done;
                        end
                    end
                end
                st_req: begin
                    if (bus.bus_gnt) begin
                        dbl             <= is_dbl(remaining);
                        bus.address_bus <= src_ptr;
                        bus.doubleRead  <= is_dbl(remaining);
                        state           <= st_rd;
                    end
                end
                st_rd: begin
                    state <= st_rdwait;
                end
                st_rdwait: begin
                    rd_buf          <= bus.incoming_data_bus;
                    bus.address_bus <= dst_ptr;
                    write_mode_q    <= 1'b1;
                    bus.doubleWrite <= dbl;
                    state           <= st_wr;
                end
                st_wr: begin
                    src_ptr   <= src_ptr + step[ADDR_W-1:0];
                    dst_ptr   <= dst_ptr + step[ADDR_W-1:0];
                    remaining <= remaining - step;
                    if (remaining == step) begin
                        bus.bus_req <= 1'b0;
                        done        <= 1'b1;
                        state       <= st_done;
                    end else begin
                        state <= st_req;
                    end
                end
                st_done: begin
                    busy  <= 1'b0;
                    state <= st_idle;
                end
                default: begin
                    busy        <= 1'b0;
                    bus.bus_req <= 1'b0;
                    state       <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_copy_engine.sv
// Bench for bus_copy_engine: byte-array memory on the data port, a
// transfer-level reference model producing the expected per-cycle bus trace.
module tb_bus_copy_engine;
    import bus_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        req;
        logic [11:0] addr;
        logic [15:0] data;
        logic        wm;
        logic        dr;
        logic        dw;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [12:0] length;
    logic        busy;
    logic        done;
    bus_state_e  state;

    bus_copy_engine_if bif ();

    bus_copy_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .bus      (bif.master),
        .state    (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [7:0]  mem [4096];
    logic [7:0]  ref_mem [4096];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;
    logic [11:0] a_nx;

    assign a_nx = bif.address_bus + 12'd1;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bif.write_mode) begin
            if (bif.doubleWrite) begin
                mem[bif.address_bus] <= bif.data_bus[15:8];
                mem[a_nx]            <= bif.data_bus[7:0];
            end else begin
                mem[bif.address_bus] <= bif.data_bus[7:0];
            end
        end
        if (bif.doubleRead)
            bif.incoming_data_bus <= {mem[bif.address_bus], mem[a_nx]};
        else
            bif.incoming_data_bus <= {8'h00, mem[bif.address_bus]};
    end

    // ---------------- scoreboard ----------------
    logic [OBS_W-1:0] exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    int    last_done_cyc = 0;
    int    act_seen = 0;
    logic        last_wr_dw;
    logic [15:0] last_wr_data;
    obs_t  act_o;
    obs_t  exp_o;

    always @(negedge clk) begin
        if (chk_en) begin
            act_o = '{busy, done, bif.bus_req, bif.address_bus, bif.data_bus,
                      bif.write_mode, bif.doubleRead, bif.doubleWrite};
            if (exp_q.size() > 0) exp_o = obs_t'(exp_q.pop_front());
            else                  exp_o = '0;
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL bus_trace cycle %0d act busy=%b done=%b req=%b addr=%h data=%h wm=%b dr=%b dw=%b exp busy=%b done=%b req=%b addr=%h data=%h wm=%b dr=%b dw=%b",
                         cyc, act_o.busy, act_o.done, act_o.req, act_o.addr, act_o.data, act_o.wm, act_o.dr, act_o.dw,
                         exp_o.busy, exp_o.done, exp_o.req, exp_o.addr, exp_o.data, exp_o.wm, exp_o.dr, exp_o.dw);
            end
            if (done) last_done_cyc = cyc;
            if (bif.bus_req || bif.write_mode || bif.doubleRead) act_seen++;
            if (bif.write_mode) begin
                last_wr_dw   = bif.doubleWrite;
                last_wr_data = bif.data_bus;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    function automatic bit gnt_at(input int k, input int lo_s, input int lo_l);
        return !(k >= lo_s && k < lo_s + lo_l);
    endfunction

    function automatic obs_t mk(input logic dn, input logic rq, input logic [11:0] a,
                                input logic [15:0] d, input logic wm, input logic dr, input logic dw);
        return '{1'b1, dn, rq, a, d, wm, dr, dw};
    endfunction

    // Expected trace: each transfer waits in REQ until granted, then takes
    // read, wait, write; a chunk of 1 or 2 bytes is read whole before written.
    task automatic run_copy(input logic [11:0] s0, input logic [11:0] d0, input logic [12:0] len,
                            input int lo_s, input int lo_l, input bit restart, output int done_off);
        int          k;
        int          n_tr;
        int          nb;
        int          e_cyc;
        int          bad;
        logic [11:0] s;
        logic [11:0] d;
        logic [12:0] rem;
        logic [7:0]  b0;
        logic [7:0]  b1;
        start = 1'b1; src_addr = s0; dst_addr = d0; length = len;
        @(posedge clk); #1;
        start = 1'b0;
        e_cyc = cyc;
        s = s0; d = d0; rem = len; k = 0;
        if (len == 13'd0) begin
            exp_q.push_back(OBS_W'(mk(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
            k = 1;
        end
        while (rem != 13'd0) begin
            while (!gnt_at(k, lo_s, lo_l)) begin
                exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0)));
                k++;
            end
            exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0)));
            nb = (rem >= 13'd2) ? 2 : 1;
            exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, s, '0, 1'b0, nb == 2, 1'b0)));
            exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0)));
            b0 = ref_mem[s];
            b1 = ref_mem[s + 12'd1];
            exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, d, (nb == 2) ? {b0, b1} : {8'h00, b0},
                                      1'b1, 1'b0, nb == 2)));
            k += 4;
            ref_mem[d] = b0;
            if (nb == 2) ref_mem[d + 12'd1] = b1;
            s   = s + 12'(nb);
            d   = d + 12'(nb);
            rem = rem - 13'(nb);
        end
        if (len != 13'd0) begin
            exp_q.push_back(OBS_W'(mk(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
            k++;
        end
        n_tr = k;
        for (int i = 0; i < n_tr; i++) begin
            bif.bus_gnt = gnt_at(i, lo_s, lo_l);
            if (restart && i == 3 && n_tr > 4) begin
                start    = 1'b1;
                src_addr = 12'($urandom);
                dst_addr = 12'($urandom);
                length   = 13'($urandom_range(1, 40));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        bif.bus_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        done_off = last_done_cyc - e_cyc + 1;
        bad = 0;
        for (int i = 0; i < int'(len); i++)
            if (mem[d0 + 12'(i)] !== ref_mem[d0 + 12'(i)]) bad++;
        check("dst_region_bad_bytes", 32'(bad), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int         doff;
    logic [7:0] old_a;
    logic [7:0] old_b;
    logic [11:0] rs;
    logic [11:0] rd;

    initial begin
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        bif.bus_gnt = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_state", 32'(state), 32'(st_idle));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_addr", 32'(bif.address_bus), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));
        poke(12'h010, 8'hAA); poke(12'h011, 8'hBB); poke(12'h012, 8'hCC); poke(12'h013, 8'hDD);

        // Two double transfers
        run_copy(12'h010, 12'h200, 13'd4, 0, 0, 1'b0, doff);
        check("len4_done_edge", 32'(doff), 32'd9);
        check("len4_dst_bytes", {mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]}, 32'hAABBCCDD);

        // Double then single
        old_a = mem[12'h022];
        run_copy(12'h020, 12'h300, 13'd3, 0, 0, 1'b0, doff);
        check("len3_done_edge", 32'(doff), 32'd9);
        check("len3_last_dw", 32'(last_wr_dw), 32'd0);
        check("len3_last_data", 32'(last_wr_data), {24'h0, old_a});
        check("len3_dst2", 32'(mem[12'h302]), {24'h0, old_a});

        // Zero length never touches the bus
        act_seen = 0;
        run_copy(12'h030, 12'h330, 13'd0, 0, 0, 1'b0, doff);
        check("len0_done_edge", 32'(doff), 32'd1);
        check("len0_bus_activity", 32'(act_seen), 32'd0);

        // Double read across the top of memory
        old_a = mem[12'hFFF];
        old_b = mem[12'h000];
        run_copy(12'hFFF, 12'h100, 13'd2, 0, 0, 1'b0, doff);
        check("wrap_dst0", 32'(mem[12'h100]), {24'h0, old_a});
        check("wrap_dst1", 32'(mem[12'h101]), {24'h0, old_b});

        // Grant withheld for 5 cycles before the second transfer
        run_copy(12'h040, 12'h140, 13'd4, 4, 5, 1'b0, doff);
        check("gnt_stall_done_edge", 32'(doff), 32'd14);

        // Reset during RD_WAIT of a 6-byte copy
        start = 1'b1; src_addr = 12'h060; dst_addr = 12'h160; length = 13'd6;
        @(posedge clk); #1;
        start = 1'b0; bif.bus_gnt = 1'b1;
        exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0)));
        exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, 12'h060, '0, 1'b0, 1'b1, 1'b0)));
        exp_q.push_back(OBS_W'(mk(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0)));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_state", 32'(state), 32'(st_idle));
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_req", 32'(bif.bus_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        run_copy(12'h050, 12'h150, 13'd2, 0, 0, 1'b0, doff);
        check("post_reset_done_edge", 32'(doff), 32'd5);

        // Randomized copies: wraps, overlaps, grant stalls, ignored restarts
        for (int t = 0; t < 12; t++) begin
            rs = ($urandom_range(0, 3) == 0) ? 12'hFF0 + 12'($urandom_range(0, 15)) : 12'($urandom);
            rd = ($urandom_range(0, 2) == 0) ? rs + 12'($urandom_range(1, 3)) : 12'($urandom);
            run_copy(rs, rd, 13'($urandom_range(0, 24)), $urandom_range(0, 12),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)), doff);
        end

        doff = 0;
        for (int i = 0; i < 4096; i++)
            if (mem[i] !== ref_mem[i]) doff++;
        check("full_memory_bad_bytes", 32'(doff), 32'd0);
        check("trace_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
